// File: rtl/phys_free_list.sv
// Physical register free list: a circular FIFO of unallocated physical
// register indices. Rename pops from the head, commit pushes superseded
// registers at the tail. Phys reg 0 is hard-zero and never enters the list.
module phys_free_list #(
    parameter int PHYS_REG_BITS = 6,
    parameter int NUM_ARCH_REGS = 32,
    parameter int DEPTH         = 2**PHYS_REG_BITS - NUM_ARCH_REGS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_req,
    output logic                       alloc_valid,
    output logic [PHYS_REG_BITS-1:0]   alloc_preg,
    input  logic                       free_req,
    input  logic [PHYS_REG_BITS-1:0]   free_preg,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    // With a power-of-two DEPTH this is exactly the pointer wrap bit.
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic                     ovf_q, ovf_d;
    logic [PTR_W-1:0]         count_w;
    logic                     do_pop;
    logic                     do_push;
    logic                     is_empty;
    logic                     is_full;

    // Occupancy and status flags derived purely from the pointers.
    always_comb begin
        count_w  = tail_q - head_q;
        is_empty = (count_w == '0);
        is_full  = (count_w == DEPTH_P);
    end

    assign count        = count_w;
    assign empty        = is_empty;
    assign full         = is_full;
    assign alloc_valid  = !is_empty;
    assign alloc_preg   = mem_q[head_q[IDX_W-1:0]];
    assign overflow_err = ovf_q;

    // Next-state pointer and error logic for pop, push and flush recovery.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        do_pop  = 1'b0;
        do_push = 1'b0;
        ovf_d   = ovf_q;
        head_d  = head_q;
        tail_d  = tail_q;

        // A zero index is never a real free, so it neither pushes nor
        // counts as an overflow attempt.
        if (free_req && (free_preg != '0)) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                do_push = 1'b1;
            end
        end
        tail_d = tail_q + PTR_W'(do_push);

        if (flush) begin
            // Everything between the committed point and the new tail is
            // free again: the list becomes full behind the updated tail.
            head_d = tail_d ^ DEPTH_P;
        end else if (alloc_req && !is_empty) begin
            do_pop = 1'b1;
            head_d = head_q + 1'b1;
        end
    end

    // Pointer and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= DEPTH_P;
            ovf_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
        end
    end

    // Index storage; reset preloads every non-architectural register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this memory is deliberately reset because its reset
            // contents are the initial free list, not don't-care data.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
            end
        end else if (do_push) begin
            mem_q[tail_q[IDX_W-1:0]] <= free_preg;
        end
    end

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list: directed scenarios plus random
// traffic compared against a push-history model of the free list.
module tb_phys_free_list;

    localparam int PRB   = 6;
    localparam int NARCH = 32;
    localparam int DEPTH = 32;

    logic           clk;
    logic           rst_n;
    logic           alloc_req;
    logic           alloc_valid;
    logic [PRB-1:0] alloc_preg;
    logic           free_req;
    logic [PRB-1:0] free_preg;
    logic           flush;
    logic [5:0]     count;
    logic           empty;
    logic           full;
    logic           overflow_err;

    int n_checks;
    int n_fail;

    // Model: the free list is always the most recent `m_cnt` indices ever
    // pushed (reset counts as pushing NUM_ARCH_REGS..63 in order).
    int m_log[$];
    int m_cnt;
    bit m_ovf;

    phys_free_list #(
        .PHYS_REG_BITS(PRB),
        .NUM_ARCH_REGS(NARCH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_preg   (alloc_preg),
        .free_req     (free_req),
        .free_preg    (free_preg),
        .flush        (flush),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_log.delete();
        for (int i = 0; i < DEPTH; i++) m_log.push_back(NARCH + i);
        m_cnt = DEPTH;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit f, input int p, input bit fl);
        bit was_full;
        bit was_empty;
        was_full  = (m_cnt == DEPTH);
        was_empty = (m_cnt == 0);
        if (f && p != 0) begin
            if (was_full) begin
                m_ovf = 1'b1;
            end else begin
                m_log.push_back(p);
                m_cnt++;
                if (m_log.size() > DEPTH) void'(m_log.pop_front());
            end
        end
        if (fl) m_cnt = DEPTH;
        else if (a && !was_empty) m_cnt--;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"}, int'(count), m_cnt);
        check({tag, ".empty"}, int'(empty), int'(m_cnt == 0));
        check({tag, ".full"}, int'(full), int'(m_cnt == DEPTH));
        check({tag, ".valid"}, int'(alloc_valid), int'(m_cnt != 0));
        check({tag, ".ovf"}, int'(overflow_err), int'(m_ovf));
        if (m_cnt != 0) check({tag, ".preg"}, int'(alloc_preg), m_log[m_log.size() - m_cnt]);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then compare.
    task automatic cycle(input bit a, input bit f, input int p, input bit fl, input string tag);
        alloc_req = a;
        free_req  = f;
        free_preg = PRB'(p);
        flush     = fl;
        @(posedge clk);
        model_step(a, f, p, fl);
        #1;
        check_model(tag);
    endtask

    // Asynchronous reset applied between edges; outputs must react at once.
    task automatic do_reset(input string tag);
        #2;
        rst_n     = 1'b0;
        alloc_req = 1'b0;
        free_req  = 1'b0;
        free_preg = '0;
        flush     = 1'b0;
        model_reset();
        #1;
        check_model(tag);
        check({tag, ".preg32"}, int'(alloc_preg), NARCH);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        alloc_req = 1'b0;
        free_req  = 1'b0;
        free_preg = '0;
        flush     = 1'b0;
        @(negedge clk);
        do_reset("rst0");

        // 1: drain the reset list in order.
        for (int i = 0; i < DEPTH; i++) begin
            check("t1.seq", int'(alloc_preg), NARCH + i);
            cycle(1, 0, 0, 0, "t1");
        end
        check("t1.empty", int'(empty), 1);
        check("t1.valid", int'(alloc_valid), 0);
        cycle(1, 0, 0, 0, "t1.stall");

        // 2: no bypass from a same-cycle free when empty.
        cycle(1, 1, 40, 0, "t2");
        check("t2.preg", int'(alloc_preg), 40);
        check("t2.count", int'(count), 1);

        // 3: steady alloc+free across the wrap point.
        do_reset("rst3");
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, "t3.a");
        for (int i = 0; i < 10; i++) cycle(1, 1, 7, 0, "t3.af");
        check("t3.count", int'(count), 27);
        for (int i = 0; i < 27; i++) cycle(1, 0, 0, 0, "t3.drain");

        // 4: overflow when full, zero index ignored.
        do_reset("rst4");
        cycle(0, 1, 50, 0, "t4.ovf");
        check("t4.ovf1", int'(overflow_err), 1);
        cycle(0, 0, 0, 0, "t4.hold");
        cycle(1, 0, 0, 0, "t4.pop");
        cycle(0, 1, 0, 0, "t4.zero");
        check("t4.count", int'(count), 31);

        // 5: flush refills the list.
        do_reset("rst5");
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, "t5.a");
        for (int i = 0; i < 3; i++) cycle(0, 1, 10 + i, 0, "t5.f");
        check("t5.count25", int'(count), 25);
        cycle(1, 1, 45, 1, "t5.flush");
        check("t5.count32", int'(count), 32);
        check("t5.full", int'(full), 1);
        cycle(0, 1, 20, 0, "t5.ovf");
        check("t5.ovf1", int'(overflow_err), 1);

        // 6 + random traffic with periodic mid-stream resets.
        for (int r = 0; r < 4; r++) begin
            do_reset("rst6");
            for (int i = 0; i < 600; i++) begin
                bit a;
                bit f;
                bit fl;
                int p;
                a  = ($urandom_range(0, 99) < 55);
                f  = ($urandom_range(0, 99) < 45);
                fl = ($urandom_range(0, 99) < 3);
                p  = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63));
                if (m_cnt == DEPTH && p == 0) p = 1;
                cycle(a, f, p, fl, "rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
